// File: rtl/nn_pkg.sv
// Shared definitions for the NN memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, requester port indices, forward_prop memory map bases, counter width.
package nn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Requester port indices (bit positions in request/grant vectors).
   localparam logic PORT_FWD = 1'b0;   // forward_prop
   localparam logic PORT_WGT = 1'b1;   // weight loader / update

   // forward_prop region bases in the MMU address space.
   localparam logic [15:0] FP_INPUT_BASE  = 16'h0000;
   localparam logic [15:0] FP_WEIGHT_BASE = 16'h0100;
   localparam logic [15:0] FP_ACT_BASE    = 16'h0200;

   // Busy-cycle counter width; covers TIMEOUT up to 255.
   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin winner select.
// Latency: combinational.
// Backpressure: none; grant is only a function of the pending requests and the last-granted port.
// Ports: i_req (pending per port), i_last (port granted last), o_grant (one-hot winner, 0 when idle).
module rr_arb2
   import nn_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_req == 2'b11) begin
         // Both pending: the port that did not win last time goes.
         o_grant[PORT_FWD] = (i_last == PORT_WGT);
         o_grant[PORT_WGT] = (i_last == PORT_FWD);
      end else begin
         o_grant = i_req;
      end
   end

endmodule

// File: rtl/nn_mem_arbiter.sv
// Two-port round-robin arbiter feeding a single outstanding request to the MMU, with busy timeout.
// Latency: accept in IDLE -> mem_valid next cycle; mem_ready -> reqN_ready next cycle; 3 cycles minimum.
// Backpressure: requesters hold valid/fields until their ready pulse; one transaction in flight at a time.
// Ports: req0_* forward_prop, req1_* weight loader; mem_* MMU side; timeout_err sticky abort flag;
//        clk single clock, rst asynchronous active-high.
module nn_mem_arbiter
   import nn_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [15:0] req0_address,
   input  logic [15:0] req0_wdata,
   output logic        req0_ready,
   output logic [15:0] req0_rdata,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [15:0] req1_address,
   input  logic [15:0] req1_wdata,
   output logic        req1_ready,
   output logic [15:0] req1_rdata,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic        timeout_err
);

   // Counter is cleared on BUSY entry, so this index is the last allowed busy cycle.
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic             r_gnt, w_gnt_n;
   logic             r_last, w_last_n;
   logic             r_mem_valid, w_mem_valid_n;
   logic             r_mem_we, w_mem_we_n;
   logic [15:0]      r_mem_address, w_mem_address_n;
   logic [15:0]      r_mem_wdata, w_mem_wdata_n;
   logic [1:0]       r_ready, w_ready_n;
   logic [15:0]      r_rdata0, w_rdata0_n;
   logic [15:0]      r_rdata1, w_rdata1_n;
   logic             r_terr, w_terr_n;

   logic [1:0]       w_req;
   logic [1:0]       w_grant;
   logic             w_sel;
   logic             w_done;
   logic [15:0]      w_resp_dat;

   assign w_req = {req1_valid, req0_valid};
   assign w_sel = w_grant[PORT_WGT];

   rr_arb2 u_rr_arb2 (
      .i_req   (w_req),
      .i_last  (r_last),
      .o_grant (w_grant)
   );

   always_comb begin
      w_state_n       = r_state;
      w_cnt_n         = r_cnt;
      w_gnt_n         = r_gnt;
      w_last_n        = r_last;
      w_mem_valid_n   = r_mem_valid;
      w_mem_we_n      = r_mem_we;
      w_mem_address_n = r_mem_address;
      w_mem_wdata_n   = r_mem_wdata;
      w_ready_n       = 2'b00;
      w_rdata0_n      = r_rdata0;
      w_rdata1_n      = r_rdata1;
      w_terr_n        = r_terr;
      w_done          = 1'b0;
      w_resp_dat      = 16'h0000;

      case (r_state)
         ST_IDLE: begin
            if (|w_grant) begin
               w_state_n       = ST_BUSY;
               w_cnt_n         = '0;
               w_gnt_n         = w_sel;
               w_mem_valid_n   = 1'b1;
               w_mem_we_n      = w_sel ? req1_we      : req0_we;
               w_mem_address_n = w_sel ? req1_address : req0_address;
               w_mem_wdata_n   = w_sel ? req1_wdata   : req0_wdata;
            end
         end
         ST_BUSY: begin
            // mem_ready is checked first so it wins over a coinciding timeout.
            if (mem_ready) begin
               w_done     = 1'b1;
               w_resp_dat = mem_rdata;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_done   = 1'b1;
               w_terr_n = 1'b1;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
            if (w_done) begin
               w_state_n        = ST_RESP;
               w_mem_valid_n    = 1'b0;
               w_last_n         = r_gnt;
               w_ready_n[r_gnt] = 1'b1;
               if (r_gnt == PORT_WGT) begin
                  w_rdata1_n = w_resp_dat;
               end else begin
                  w_rdata0_n = w_resp_dat;
               end
            end
         end
         ST_RESP: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_gnt         <= PORT_FWD;
         r_last        <= PORT_WGT;   // so port 0 wins the first contention
         r_mem_valid   <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_address <= 16'h0000;
         r_mem_wdata   <= 16'h0000;
         r_ready       <= 2'b00;
         r_rdata0      <= 16'h0000;
         r_rdata1      <= 16'h0000;
         r_terr        <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_cnt         <= w_cnt_n;
         r_gnt         <= w_gnt_n;
         r_last        <= w_last_n;
         r_mem_valid   <= w_mem_valid_n;
         r_mem_we      <= w_mem_we_n;
         r_mem_address <= w_mem_address_n;
         r_mem_wdata   <= w_mem_wdata_n;
         r_ready       <= w_ready_n;
         r_rdata0      <= w_rdata0_n;
         r_rdata1      <= w_rdata1_n;
         r_terr        <= w_terr_n;
      end
   end

   assign mem_valid   = r_mem_valid;
   assign mem_we      = r_mem_we;
   assign mem_address = r_mem_address;
   assign mem_wdata   = r_mem_wdata;
   assign req0_ready  = r_ready[PORT_FWD];
   assign req1_ready  = r_ready[PORT_WGT];
   assign req0_rdata  = r_rdata0;
   assign req1_rdata  = r_rdata1;
   assign timeout_err = r_terr;

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Self-checking bench for nn_mem_arbiter with a behavioural MMU and per-port scoreboards.
// Latency: n/a.
// Backpressure: requester model holds valid and fields until its ready pulse.
module tb_nn_mem_arbiter;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid, req0_we, req0_ready;
   logic [15:0] req0_address, req0_wdata, req0_rdata;
   logic        req1_valid, req1_we, req1_ready;
   logic [15:0] req1_address, req1_wdata, req1_rdata;
   logic        mem_valid, mem_we, mem_ready, timeout_err;
   logic [15:0] mem_address, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   nn_mem_arbiter #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_we      (req0_we),
      .req0_address (req0_address),
      .req0_wdata   (req0_wdata),
      .req0_ready   (req0_ready),
      .req0_rdata   (req0_rdata),
      .req1_valid   (req1_valid),
      .req1_we      (req1_we),
      .req1_address (req1_address),
      .req1_wdata   (req1_wdata),
      .req1_ready   (req1_ready),
      .req1_rdata   (req1_rdata),
      .mem_valid    (mem_valid),
      .mem_we       (mem_we),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .timeout_err  (timeout_err)
   );

   typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; logic drop; } stim_t;
   typedef struct packed { logic [15:0] rdata; logic [31:0] lat; } exp_t;
   typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; } memtx_t;

   stim_t       stim0[$], stim1[$];
   exp_t        exp0[$], exp1[$];
   memtx_t      glog[$];
   memtx_t      rise_tx;
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          t_rise = 0;
   int          busy_cyc = 0;
   int          mmu_lat = 1;     // busy cycle in which the MMU answers; 0 = never
   bit          junk = 1'b0;     // drive mem_ready while no request is outstanding
   bit          prev_mv = 1'b0;
   bit          drop0 = 1'b0;
   bit          drop1 = 1'b0;
   logic [15:0] last_rd0 = 16'h0000;
   logic [15:0] last_rd1 = 16'h0000;

   function automatic logic [15:0] mmu_data(input logic [15:0] a);
      return {8'h00, a[7:0] ^ 8'hA0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic enq(input bit port, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input bit drop,
                      input logic [15:0] rdata, input int lat);
      stim_t s;
      exp_t  e;
      s = '{we, addr, wdata, drop};
      e = '{rdata, 32'(lat)};
      if (port) begin
         stim1.push_back(s);
         exp1.push_back(e);
      end else begin
         stim0.push_back(s);
         exp0.push_back(e);
      end
   endtask

   // One clock: score responses, watch the MMU side, model the MMU, drive requesters.
   task automatic step();
      exp_t  e;
      stim_t s;
      @(negedge clk);
      cyc++;
      if (req0_ready) begin
         if (exp0.size() == 0) check("r0_unexpected_ready", 64'(req0_ready), 64'd0);
         else begin
            e = exp0.pop_front();
            check("r0_rdata", 64'(req0_rdata), 64'(e.rdata));
            check("r0_latency", 64'(cyc - t_rise), 64'(e.lat));
            last_rd0 = e.rdata;
         end
         check("r0_excl", 64'(req1_ready), 64'd0);
         check("r1_rdata_hold", 64'(req1_rdata), 64'(last_rd1));
      end
      if (req1_ready) begin
         if (exp1.size() == 0) check("r1_unexpected_ready", 64'(req1_ready), 64'd0);
         else begin
            e = exp1.pop_front();
            check("r1_rdata", 64'(req1_rdata), 64'(e.rdata));
            check("r1_latency", 64'(cyc - t_rise), 64'(e.lat));
            last_rd1 = e.rdata;
         end
         check("r0_rdata_hold", 64'(req0_rdata), 64'(last_rd0));
      end

      if (mem_valid && !prev_mv) begin
         t_rise   = cyc;
         busy_cyc = 0;
         rise_tx  = '{mem_we, mem_address, mem_wdata};
         glog.push_back(rise_tx);
      end
      prev_mv   = mem_valid;
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      if (mem_valid) begin
         busy_cyc++;
         if (busy_cyc == mmu_lat) begin
            mem_ready = 1'b1;
            mem_rdata = mmu_data(rise_tx.addr);
            check("mem_stable", 64'({mem_we, mem_address, mem_wdata}), 64'(rise_tx));
         end
      end else if (junk) begin
         mem_ready = 1'b1;
      end

      if (!req0_valid || req0_ready) begin
         if (stim0.size() != 0) begin
            s = stim0.pop_front();
            req0_valid = 1'b1; req0_we = s.we; req0_address = s.addr; req0_wdata = s.wdata; drop0 = s.drop;
         end else req0_valid = 1'b0;
      end else if (drop0 && mem_valid) req0_valid = 1'b0;
      if (!req1_valid || req1_ready) begin
         if (stim1.size() != 0) begin
            s = stim1.pop_front();
            req1_valid = 1'b1; req1_we = s.we; req1_address = s.addr; req1_wdata = s.wdata; drop1 = s.drop;
         end else req1_valid = 1'b0;
      end else if (drop1 && mem_valid) req1_valid = 1'b0;
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((exp0.size() + exp1.size()) != 0 && n < budget) begin
         step();
         n++;
      end
      check("run_complete", 64'(exp0.size() + exp1.size()), 64'd0);
      step();
      step();
   endtask

   task automatic flush();
      stim0.delete(); stim1.delete(); exp0.delete(); exp1.delete(); glog.delete();
      req0_valid = 1'b0; req1_valid = 1'b0; drop0 = 1'b0; drop1 = 1'b0;
      last_rd0 = 16'h0000; last_rd1 = 16'h0000; prev_mv = 1'b0;
   endtask

   task automatic check_zero(input string p);
      check({p, "_mem_valid"},   64'(mem_valid),   64'd0);
      check({p, "_mem_we"},      64'(mem_we),      64'd0);
      check({p, "_mem_address"}, 64'(mem_address), 64'd0);
      check({p, "_mem_wdata"},   64'(mem_wdata),   64'd0);
      check({p, "_req0_ready"},  64'(req0_ready),  64'd0);
      check({p, "_req1_ready"},  64'(req1_ready),  64'd0);
      check({p, "_req0_rdata"},  64'(req0_rdata),  64'd0);
      check({p, "_req1_rdata"},  64'(req1_rdata),  64'd0);
      check({p, "_timeout_err"}, 64'(timeout_err), 64'd0);
   endtask

   initial begin
      int n;
      req0_valid = 1'b0; req0_we = 1'b0; req0_address = 16'h0000; req0_wdata = 16'h0000;
      req1_valid = 1'b0; req1_we = 1'b0; req1_address = 16'h0000; req1_wdata = 16'h0000;
      mem_ready = 1'b0; mem_rdata = 16'h0000;
      step();
      step();
      check_zero("reset");
      rst = 1'b0;
      step();

      // Contention from reset: grants 0,1,0,1.
      mmu_lat = 2;
      enq(1'b0, 1'b0, 16'h0111, 16'h0000, 1'b0, mmu_data(16'h0111), 2);
      enq(1'b0, 1'b0, 16'h0111, 16'h0000, 1'b0, mmu_data(16'h0111), 2);
      enq(1'b1, 1'b0, 16'h0333, 16'h0000, 1'b0, mmu_data(16'h0333), 2);
      enq(1'b1, 1'b0, 16'h0333, 16'h0000, 1'b0, mmu_data(16'h0333), 2);
      run(80);
      check("cont_count", 64'(glog.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < glog.size())
            check("cont_addr", 64'(glog[i].addr), (i % 2 == 0) ? 64'h0111 : 64'h0333);
      end
      glog.delete();

      // Single read, answered in the 3rd busy cycle.
      mmu_lat = 3;
      enq(1'b0, 1'b0, 16'h0105, 16'h0000, 1'b0, 16'h00A5, 3);
      run(40);
      check("rd_count", 64'(glog.size()), 64'd1);
      glog.delete();

      // Write from port 1 with stray mem_ready outside BUSY.
      mmu_lat = 2;
      junk = 1'b1;
      step();
      enq(1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, mmu_data(16'h0200), 2);
      run(40);
      junk = 1'b0;
      check("wr_count", 64'(glog.size()), 64'd1);
      if (glog.size() != 0) begin
         check("wr_mem_we",    64'(glog[0].we),    64'd1);
         check("wr_mem_addr",  64'(glog[0].addr),  64'h0200);
         check("wr_mem_wdata", 64'(glog[0].wdata), 64'h1234);
      end
      glog.delete();

      // mem_ready in the last allowed busy cycle wins over the timeout.
      mmu_lat = TMO;
      enq(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, mmu_data(16'h0042), TMO);
      run(40);
      check("coinc_terr", 64'(timeout_err), 64'd0);

      // Port 1 drops valid during BUSY; the transaction still completes.
      mmu_lat = 3;
      enq(1'b1, 1'b0, 16'h0377, 16'h0000, 1'b1, mmu_data(16'h0377), 3);
      run(40);

      // Timeout: MMU never answers.
      mmu_lat = 0;
      enq(1'b0, 1'b0, 16'h0105, 16'h0000, 1'b0, 16'h0000, TMO);
      run(40);
      check("tmo_terr", 64'(timeout_err), 64'd1);
      mmu_lat = 1;
      enq(1'b0, 1'b0, 16'h0042, 16'h0000, 1'b0, mmu_data(16'h0042), 1);
      run(40);
      check("tmo_terr_sticky", 64'(timeout_err), 64'd1);

      // Reset in BUSY, then port 0 must win contention again.
      glog.delete();
      mmu_lat = 0;
      enq(1'b0, 1'b0, 16'h0105, 16'h0000, 1'b0, 16'h0000, TMO);
      n = 0;
      while (!mem_valid && n < 10) begin
         step();
         n++;
      end
      check("rb_busy_reached", 64'(mem_valid), 64'd1);
      rst = 1'b1;
      #1;
      check_zero("rst_busy");
      flush();
      step();
      step();
      rst = 1'b0;
      mmu_lat = 1;
      enq(1'b1, 1'b0, 16'h0333, 16'h0000, 1'b0, mmu_data(16'h0333), 1);
      enq(1'b0, 1'b0, 16'h0111, 16'h0000, 1'b0, mmu_data(16'h0111), 1);
      run(40);
      check("rb_count", 64'(glog.size()), 64'd2);
      if (glog.size() == 2) begin
         check("rb_first_port0", 64'(glog[0].addr), 64'h0111);
         check("rb_second_port1", 64'(glog[1].addr), 64'h0333);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
